// File: rtl/fb_rect_fill.sv
// Solid-colour rectangle fill engine driving the write side of a frame buffer.
// It accepts one command at a time and clips it to the write space. It then
// emits one registered pixel write per clock. Buffer swaps are deferred until
// any in-flight rectangle has finished drawing.
module fb_rect_fill #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    cmd_valid_in,
  output logic                                    cmd_ready_out,
  input  logic [$clog2(FB_WIDTH)-1:0]             cmd_x_in,
  input  logic [$clog2(FB_HEIGHT)-1:0]            cmd_y_in,
  input  logic [$clog2(FB_WIDTH)-1:0]             cmd_w_in,
  input  logic [$clog2(FB_HEIGHT)-1:0]            cmd_h_in,
  input  logic [15:0]                             cmd_color_in,
  input  logic                                    swap_req_in,
  output logic [15:0]                             write_data_out,
  output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]   write_addr_out,
  output logic                                    write_enable_out,
  output logic                                    swap_buffer_out,
  output logic                                    busy_out
);

  localparam int X_WIDTH    = $clog2(FB_WIDTH);
  localparam int Y_WIDTH    = $clog2(FB_HEIGHT);
  localparam int ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT);

  localparam logic [X_WIDTH:0]      X_LIMIT = (X_WIDTH+1)'(FB_WIDTH);
  localparam logic [Y_WIDTH:0]      Y_LIMIT = (Y_WIDTH+1)'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

  typedef enum logic [1:0] {IDLE, FILL, SWAP} state_t;

  state_t                  state_reg, state_next;
  logic                    swap_pend_reg, swap_pend_next;
  logic [X_WIDTH-1:0]      x0_reg, x0_next;
  logic [X_WIDTH-1:0]      cur_x_reg, cur_x_next;
  logic [Y_WIDTH-1:0]      cur_y_reg, cur_y_next;
  logic [X_WIDTH:0]        x_end_reg, x_end_next;
  logic [Y_WIDTH:0]        y_end_reg, y_end_next;
  logic [ADDR_WIDTH-1:0]   row_base_reg, row_base_next;
  logic [15:0]             write_data_reg, write_data_next;
  logic [ADDR_WIDTH-1:0]   write_addr_reg, write_addr_next;
  logic                    write_en_reg, write_en_next;
  logic                    swap_reg, swap_next;

  // Command decode: one-bit-wider sums so the clip comparison never wraps.
  logic [X_WIDTH:0]        x_sum;
  logic [Y_WIDTH:0]        y_sum;
  logic [X_WIDTH:0]        x_clip;
  logic [Y_WIDTH:0]        y_clip;
  logic [ADDR_WIDTH-1:0]   cmd_row_base;
  logic                    cmd_empty;
  logic                    accept;
  logic                    last_col;
  logic                    last_row;

  assign x_sum        = {1'b0, cmd_x_in} + {1'b0, cmd_w_in};
  assign y_sum        = {1'b0, cmd_y_in} + {1'b0, cmd_h_in};
  assign x_clip       = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
  assign y_clip       = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
  assign cmd_row_base = ADDR_WIDTH'(cmd_y_in) * ROW_STEP;
  assign cmd_empty    = (cmd_w_in == '0) || (cmd_h_in == '0) ||
                        ({1'b0, cmd_x_in} >= X_LIMIT) || ({1'b0, cmd_y_in} >= Y_LIMIT);

  assign cmd_ready_out = (state_reg == IDLE) && !swap_pend_reg && rst_n_in;
  assign accept        = cmd_valid_in && cmd_ready_out;
  assign busy_out      = (state_reg != IDLE) || swap_pend_reg;

  // The pixel currently on the bus is (cur_x, cur_y); these flag its position.
  assign last_col = ({1'b0, cur_x_reg} == (x_end_reg - 1'b1));
  assign last_row = ({1'b0, cur_y_reg} == (y_end_reg - 1'b1));

  assign write_data_out   = write_data_reg;
  assign write_addr_out   = write_addr_reg;
  assign write_enable_out = write_en_reg;
  assign swap_buffer_out  = swap_reg;

  // State and output registers; reset clears every strobe immediately.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= IDLE;
      swap_pend_reg  <= 1'b0;
      x0_reg         <= '0;
      cur_x_reg      <= '0;
      cur_y_reg      <= '0;
      x_end_reg      <= '0;
      y_end_reg      <= '0;
      row_base_reg   <= '0;
      write_data_reg <= '0;
      write_addr_reg <= '0;
      write_en_reg   <= 1'b0;
      swap_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      swap_pend_reg  <= swap_pend_next;
      x0_reg         <= x0_next;
      cur_x_reg      <= cur_x_next;
      cur_y_reg      <= cur_y_next;
      x_end_reg      <= x_end_next;
      y_end_reg      <= y_end_next;
      row_base_reg   <= row_base_next;
      write_data_reg <= write_data_next;
      write_addr_reg <= write_addr_next;
      write_en_reg   <= write_en_next;
      swap_reg       <= swap_next;
    end
  end

  // Next-state logic: accept/clip, raster walk with additive row step, swap sequencing.
  always_comb begin
    state_next      = state_reg;
    x0_next         = x0_reg;
    cur_x_next      = cur_x_reg;
    cur_y_next      = cur_y_reg;
    x_end_next      = x_end_reg;
    y_end_next      = y_end_reg;
    row_base_next   = row_base_reg;
    write_data_next = write_data_reg;
    write_addr_next = write_addr_reg;
    write_en_next   = 1'b0;
    swap_next       = 1'b0;
    // A request always sets the pending flag, even in the cycle it is serviced.
    swap_pend_next  = swap_req_in || (swap_pend_reg && (state_reg != SWAP));

    case (state_reg)
      IDLE: begin
        if (accept && !cmd_empty) begin
          state_next      = FILL;
          x0_next         = cmd_x_in;
          cur_x_next      = cmd_x_in;
          cur_y_next      = cmd_y_in;
          x_end_next      = x_clip;
          y_end_next      = y_clip;
          row_base_next   = cmd_row_base;
          write_data_next = cmd_color_in;
          write_addr_next = cmd_row_base + ADDR_WIDTH'(cmd_x_in);
          write_en_next   = 1'b1;
        end else if (swap_pend_reg) begin
          state_next = SWAP;
          swap_next  = 1'b1;
        end
      end
      FILL: begin
        if (last_col && last_row) begin
          if (swap_pend_reg) begin
            state_next = SWAP;
            swap_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (last_col) begin
          write_en_next   = 1'b1;
          cur_x_next      = x0_reg;
          cur_y_next      = cur_y_reg + 1'b1;
          row_base_next   = row_base_reg + ROW_STEP;
          write_addr_next = row_base_reg + ROW_STEP + ADDR_WIDTH'(x0_reg);
        end else begin
          write_en_next   = 1'b1;
          cur_x_next      = cur_x_reg + 1'b1;
          write_addr_next = row_base_reg + ADDR_WIDTH'(cur_x_reg) + 1'b1;
        end
      end
      SWAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: each task drives one scenario and checks inline.
module tb_fb_rect_fill;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        swap_req;
  logic [15:0] write_data;
  logic [15:0] write_addr;
  logic        write_enable;
  logic        swap_buffer;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int write_count = 0;
  int swap_count = 0;

  fb_rect_fill dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .cmd_valid_in     (cmd_valid),
    .cmd_ready_out    (cmd_ready),
    .cmd_x_in         (cmd_x),
    .cmd_y_in         (cmd_y),
    .cmd_w_in         (cmd_w),
    .cmd_h_in         (cmd_h),
    .cmd_color_in     (cmd_color),
    .swap_req_in      (swap_req),
    .write_data_out   (write_data),
    .write_addr_out   (write_addr),
    .write_enable_out (write_enable),
    .swap_buffer_out  (swap_buffer),
    .busy_out         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (write_enable === 1'b1) write_count++;
    if (swap_buffer === 1'b1) swap_count++;
  end

  // Presents a command for one cycle; called at a negedge while ready is high.
  task automatic send_cmd(input logic [8:0] x, input logic [7:0] y,
                          input logic [8:0] w, input logic [7:0] h, input logic [15:0] c);
    cmd_valid = 1'b1; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", write_enable); end
    vectors++; if (swap_buffer !== 1'b0) begin miscompares++; $display("FAIL reset_swap: got %b want 0", swap_buffer); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    vectors++; if (write_addr !== 16'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", write_addr); end
    vectors++; if (write_data !== 16'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", write_data); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", cmd_ready); end
    vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL release_we: got %b want 0", write_enable); end
    $display("reset: done, ready=%b", cmd_ready);
  endtask

  task automatic test_basic_fill;
    logic [15:0] exp_addr [6];
    exp_addr = '{16'd962, 16'd963, 16'd964, 16'd1282, 16'd1283, 16'd1284};
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL basic_pre_ready: got %b want 1", cmd_ready); end
    send_cmd(9'd2, 8'd3, 9'd3, 8'd2, 16'hF800);
    for (int i = 0; i < 6; i++) begin
      vectors++; if (write_enable !== 1'b1) begin miscompares++; $display("FAIL basic_we[%0d]: got %b want 1", i, write_enable); end
      vectors++; if (write_addr !== exp_addr[i]) begin miscompares++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, write_addr, exp_addr[i]); end
      vectors++; if (write_data !== 16'hF800) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want F800", i, write_data); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready[%0d]: got %b want 0", i, cmd_ready); end
      @(negedge clk);
    end
    vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL basic_end_we: got %b want 0", write_enable); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL basic_end_ready: got %b want 1", cmd_ready); end
    vectors++; if (write_addr !== 16'd1284) begin miscompares++; $display("FAIL basic_hold_addr: got %0d want 1284", write_addr); end
    $display("basic_fill: 6 strobes 962..1284 checked");
  endtask

  task automatic test_back_to_back;
    send_cmd(9'd1, 8'd0, 9'd2, 8'd1, 16'h1111);
    vectors++; if (write_addr !== 16'd1 || write_enable !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got we=%b addr=%0d want we=1 addr=1", write_enable, write_addr); end
    vectors++; if (write_data !== 16'h1111) begin miscompares++; $display("FAIL b2b_data: got %h want 1111", write_data); end
    @(negedge clk);
    vectors++; if (write_addr !== 16'd2 || write_enable !== 1'b1) begin miscompares++; $display("FAIL b2b_second: got we=%b addr=%0d want we=1 addr=2", write_enable, write_addr); end
    @(negedge clk);
    vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", write_enable); end
    $display("back_to_back: second command strobes at 1,2");
  endtask

  task automatic test_clipping;
    int snap;
    send_cmd(9'd318, 8'd179, 9'd5, 8'd4, 16'h07E0);
    vectors++; if (write_enable !== 1'b1 || write_addr !== 16'd57598) begin miscompares++; $display("FAIL clip_px0: got we=%b addr=%0d want we=1 addr=57598", write_enable, write_addr); end
    @(negedge clk);
    vectors++; if (write_enable !== 1'b1 || write_addr !== 16'd57599) begin miscompares++; $display("FAIL clip_px1: got we=%b addr=%0d want we=1 addr=57599", write_enable, write_addr); end
    @(negedge clk);
    vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL clip_end: got %b want 0", write_enable); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL clip_ready: got %b want 1", cmd_ready); end
    snap = write_count;
    // Off-screen and zero-size commands, one per cycle.
    send_cmd(9'd320, 8'd0, 9'd4, 8'd1, 16'hFFFF);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL empty_ready0: got %b want 1", cmd_ready); end
    send_cmd(9'd10, 8'd10, 9'd0, 8'd3, 16'hFFFF);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL empty_ready1: got %b want 1", cmd_ready); end
    send_cmd(9'd10, 8'd180, 9'd2, 8'd2, 16'hFFFF);
    vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL empty_ready2: got ready=%b busy=%b want 1,0", cmd_ready, busy); end
    repeat (3) @(negedge clk);
    vectors++; if (write_count != snap) begin miscompares++; $display("FAIL empty_writes: got %0d want 0", write_count - snap); end
    $display("clipping: 2 strobes at 57598/57599, empty commands gave %0d writes", write_count - snap);
  endtask

  task automatic test_swap_during_fill;
    int snap;
    snap = swap_count;
    send_cmd(9'd0, 8'd0, 9'd4, 8'd1, 16'h001F);
    vectors++; if (write_addr !== 16'd0 || write_enable !== 1'b1) begin miscompares++; $display("FAIL sf_addr0: got we=%b addr=%0d want 1,0", write_enable, write_addr); end
    @(negedge clk);
    vectors++; if (write_addr !== 16'd1 || write_enable !== 1'b1) begin miscompares++; $display("FAIL sf_addr1: got we=%b addr=%0d want 1,1", write_enable, write_addr); end
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    vectors++; if (write_addr !== 16'd2 || write_enable !== 1'b1) begin miscompares++; $display("FAIL sf_addr2: got we=%b addr=%0d want 1,2", write_enable, write_addr); end
    @(negedge clk);
    vectors++; if (write_addr !== 16'd3 || write_enable !== 1'b1 || swap_buffer !== 1'b0) begin miscompares++; $display("FAIL sf_addr3: got we=%b addr=%0d swap=%b want 1,3,0", write_enable, write_addr, swap_buffer); end
    @(negedge clk);
    vectors++; if (swap_buffer !== 1'b1 || write_enable !== 1'b0 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL sf_pulse: got swap=%b we=%b ready=%b want 1,0,0", swap_buffer, write_enable, cmd_ready); end
    @(negedge clk);
    vectors++; if (swap_buffer !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL sf_after: got swap=%b ready=%b busy=%b want 0,1,0", swap_buffer, cmd_ready, busy); end
    vectors++; if (swap_count - snap != 1) begin miscompares++; $display("FAIL sf_count: got %0d want 1", swap_count - snap); end
    $display("swap_during_fill: swap pulse after address 3");
  endtask

  task automatic test_idle_swap;
    int snap;
    snap = swap_count;
    swap_req = 1'b1;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL is_pend: got ready=%b busy=%b want 0,1", cmd_ready, busy); end
    cmd_valid = 1'b1; cmd_x = 9'd5; cmd_y = 8'd5; cmd_w = 9'd1; cmd_h = 8'd1; cmd_color = 16'hAAAA;
    @(negedge clk);
    swap_req = 1'b0;
    vectors++; if (swap_buffer !== 1'b1 || cmd_ready !== 1'b0 || write_enable !== 1'b0) begin miscompares++; $display("FAIL is_pulse: got swap=%b ready=%b we=%b want 1,0,0", swap_buffer, cmd_ready, write_enable); end
    @(negedge clk);
    vectors++; if (swap_buffer !== 1'b0 || cmd_ready !== 1'b1 || write_enable !== 1'b0) begin miscompares++; $display("FAIL is_post: got swap=%b ready=%b we=%b want 0,1,0", swap_buffer, cmd_ready, write_enable); end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++; if (write_enable !== 1'b1 || write_addr !== 16'd1605 || write_data !== 16'hAAAA) begin miscompares++; $display("FAIL is_write: got we=%b addr=%0d data=%h want 1,1605,AAAA", write_enable, write_addr, write_data); end
    repeat (4) @(negedge clk);
    vectors++; if (swap_count - snap != 1) begin miscompares++; $display("FAIL is_count: got %0d want 1", swap_count - snap); end
    $display("idle_swap: merged into %0d pulse, command at 1605", swap_count - snap);
  endtask

  task automatic test_swap_repeat;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    vectors++; if (swap_buffer !== 1'b0) begin miscompares++; $display("FAIL sr_wait: got %b want 0", swap_buffer); end
    @(negedge clk);
    vectors++; if (swap_buffer !== 1'b1) begin miscompares++; $display("FAIL sr_first: got %b want 1", swap_buffer); end
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    vectors++; if (swap_buffer !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL sr_gap: got swap=%b busy=%b ready=%b want 0,1,0", swap_buffer, busy, cmd_ready); end
    @(negedge clk);
    vectors++; if (swap_buffer !== 1'b1) begin miscompares++; $display("FAIL sr_second: got %b want 1", swap_buffer); end
    @(negedge clk);
    vectors++; if (swap_buffer !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL sr_done: got swap=%b ready=%b want 0,1", swap_buffer, cmd_ready); end
    $display("swap_repeat: second swap after one idle cycle");
  endtask

  task automatic test_reset_mid_fill;
    int snap_w;
    int snap_s;
    send_cmd(9'd0, 8'd10, 9'd10, 8'd1, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (write_enable !== 1'b1 || write_addr !== 16'd3202) begin miscompares++; $display("FAIL rm_third: got we=%b addr=%0d want 1,3202", write_enable, write_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if (write_enable !== 1'b0 || write_addr !== 16'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rm_drop: got we=%b addr=%0d busy=%b want 0,0,0", write_enable, write_addr, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap_w = write_count;
    snap_s = swap_count;
    repeat (15) @(negedge clk);
    vectors++; if (write_count != snap_w) begin miscompares++; $display("FAIL rm_writes: got %0d want 0", write_count - snap_w); end
    vectors++; if (swap_count != snap_s) begin miscompares++; $display("FAIL rm_swaps: got %0d want 0", swap_count - snap_s); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
    $display("reset_mid_fill: %0d writes, %0d swaps after release", write_count - snap_w, swap_count - snap_s);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; swap_req = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    test_reset;
    test_basic_fill;
    test_back_to_back;
    test_clipping;
    test_swap_during_fill;
    test_idle_swap;
    test_swap_repeat;
    test_reset_mid_fill;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fb_rect_fill.md
# fb_rect_fill

Rectangle-fill draw engine that sits directly upstream of `frame_buffer` and drives its WRITE side. It accepts one solid-colour rectangle command at a time through a valid/ready handshake. It clips the rectangle to the 320x180 write space and emits one 565-format pixel write per clock. It also sequences buffer-swap requests so that a swap is never issued while a rectangle is partially drawn.

## Interface
Parameters:
- `FB_WIDTH`, default 320: write-space width in pixels.
- `FB_HEIGHT`, default 180: write-space height in pixels.
- `X_WIDTH` (localparam), `$clog2(FB_WIDTH)` (9): width of the x and w fields.
- `Y_WIDTH` (localparam), `$clog2(FB_HEIGHT)` (8): width of the y and h fields.
- `ADDR_WIDTH` (localparam), `$clog2(FB_WIDTH*FB_HEIGHT)` (16): width of the write address.

Ports (one clock, `clk_in`; reset `rst_n_in` is asynchronous and active-low):
- `clk_in`  in  1  clock; also drives the frame buffer's `write_clk`.
- `rst_n_in`  in  1  asynchronous active-low reset.
- `cmd_valid_in`  in  1  a rectangle command is presented.
- `cmd_ready_out`  out  1  the command is accepted on a cycle where valid && ready.
- `cmd_x_in`  in  X_WIDTH  left column.
- `cmd_y_in`  in  Y_WIDTH  top row.
- `cmd_w_in`  in  X_WIDTH  width in pixels.
- `cmd_h_in`  in  Y_WIDTH  height in pixels.
- `cmd_color_in`  in  16  565 RGB fill colour.
- `swap_req_in`  in  1  single-cycle request to swap buffers after all accepted commands finish.
- `write_data_out`  out  16  pixel colour, connected to the bus `write_data`.
- `write_addr_out`  out  ADDR_WIDTH  pixel address `y*FB_WIDTH + x`, connected to the bus `write_addr`.
- `write_enable_out`  out  1  single-cycle write strobe per pixel.
- `swap_buffer_out`  out  1  single-cycle pulse, connected to the bus `swap_buffer`.
- `busy_out`  out  1  high when the state is not IDLE or a swap is pending.

## Operation
States:
- **IDLE.** `cmd_ready_out = (state==IDLE) && !swap_pend && rst_n_in`.
  - Accepting a command latches the colour and computes the clipped extents:
    - `x_end = min(x+w, FB_WIDTH)` and `y_end = min(y+h, FB_HEIGHT)`, using (X_WIDTH+1)- and (Y_WIDTH+1)-bit sums; the sums never wrap.
    - `row_base = y*FB_WIDTH`.
  - If `w==0`, `h==0`, `x>=FB_WIDTH` or `y>=FB_HEIGHT`, the command is consumed with no writes and the state stays IDLE.
  - Otherwise the next state is FILL.
  - If `swap_pend` is set and no command is being accepted, the next state is SWAP.
- **FILL.** Each cycle issues one write at `row_base + cur_x`, then advances:
  - `cur_x++`.
  - At `cur_x == x_end-1`: `cur_x <= x0`, `cur_y++`, `row_base += FB_WIDTH`. Row advance uses this addition only; there is no multiplier in FILL.
  - Last pixel (`cur_x == x_end-1 && cur_y == y_end-1`): next state is SWAP if `swap_pend` is set, else IDLE.
- **SWAP.** Drives `swap_buffer_out` for exactly one cycle, clears `swap_pend`, and returns to IDLE.

Swap rules:
- A `swap_req_in` in any state sets `swap_pend`. Repeated requests before the swap executes merge into one swap.
- If a request arrives in the same cycle that a command is accepted, the command is ordered first: the swap follows that command's last write.
- `swap_req_in` during SWAP sets `swap_pend` again, giving a second swap after one IDLE cycle.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state IDLE, `swap_pend=0`.
  - `write_enable_out`, `swap_buffer_out`, `busy_out`, `cmd_ready_out` are 0.
  - `write_addr_out` and `write_data_out` are 0.
  - Asserting reset mid-FILL or mid-SWAP drops all strobes in the same instant. No further writes or swaps are issued after release.
- Outputs `write_*` and `swap_buffer_out` are registered. The first write strobe is visible the cycle after acceptance.
- A clipped rectangle of cw x ch produces exactly cw*ch back-to-back strobes with no gaps between rows.
- `cmd_ready_out` rises the cycle after the last strobe. The next command's first write can therefore follow one idle cycle later.
- An empty command holds ready high continuously, allowing one accept per cycle.
- `swap_buffer_out` pulses the cycle after the last write strobe of the preceding command, or 2 cycles after the request when idle.
- `write_data_out` and `write_addr_out` are held stable when `write_enable_out` is low.

## Test plan
- **Reset:** hold `rst_n_in=0`, then release → all outputs 0 during reset; `cmd_ready_out=1` on the first cycle after release; no strobes.
- **Basic fill:** x=2, y=3, w=3, h=2, colour 16'hF800 → six consecutive strobes with addresses 962, 963, 964, 1282, 1283, 1284 and data F800; ready stays low through them.
- **Clipping:** x=318, y=179, w=5, h=4 → exactly two strobes, at 57598 and 57599. A command with x=320 and w=4 → zero strobes, consumed in one cycle.
- **Swap during fill:** 4x1 rectangle at (0,0) with `swap_req_in` pulsed during the second write → strobes at addresses 0..3, then `swap_buffer_out` high for one cycle immediately after address 3; ready low until after the pulse.
- **Idle swap plus command:** pulse `swap_req_in` twice while idle, with `cmd_valid_in` held → exactly one swap pulse; the command is accepted only after the pulse.
- **Reset mid-fill:** assert reset during the third strobe of a 10x1 rectangle → strobes stop at once; after release, zero further writes and zero swaps.
